// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, lock-state encoding and checksum step for the VGA receiver.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int WHOLE_LINE  = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int WHOLE_FRAME = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Wide enough for twice the longest period plus one saturation step.
    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } lock_state_t;

    function automatic logic [15:0] cs_step(input logic [15:0] cs, input logic [11:0] rgb);
        return {cs[14:0], cs[15]} ^ {4'b0000, rgb};
    endfunction

endpackage

// File: rtl/sync_edge_meter.sv
// Falling-edge detector with period, low-width and timeout measurement counted in enable ticks.
module sync_edge_meter
    import vga_pkg::*;
#(
    parameter int LIMIT = 2 * WHOLE_LINE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_staged,
    input  logic             sig_in,
    input  logic             en,
    output logic             fall,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] width,
    output logic             timeout
);

    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] width_cnt_reg;
    logic [CNT_W-1:0] width_reg;
    logic             rise;
    logic [CNT_W-1:0] en_tick;

    assign fall    = sig_staged & ~sig_in;
    assign rise    = ~sig_staged & sig_in;
    assign en_tick = {{(CNT_W-1){1'b0}}, en};
    assign period  = period_reg;
    assign width   = width_reg;
    // One pulse per stall: the counter steps past LIMIT once and then holds.
    assign timeout = ~fall & en & (period_reg == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            period_reg    <= '0;
            width_cnt_reg <= '0;
            width_reg     <= '0;
        end else begin
            if (fall) begin
                period_reg    <= en_tick;
                width_cnt_reg <= en_tick;
            end else begin
                if (en && (period_reg <= CNT_W'(LIMIT)))
                    period_reg <= period_reg + 1'b1;
                if (en && !sig_in)
                    width_cnt_reg <= width_cnt_reg + 1'b1;
            end
            if (rise)
                width_reg <= width_cnt_reg;
        end
    end

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA sink: stages sync/colour, recovers x/y, checks line/frame timing and tracks lock.
// Optional frame checksum is built only when FRAME_CHECKSUM_EN is defined.
module vga_timing_receiver
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic [9:0]  position_x,
    output logic [8:0]  position_y,
    output logic        visible,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out,
    output logic        locked,
    output logic [15:0] frame_count,
    output logic [7:0]  error_count,
    output logic [15:0] frame_checksum,
    output logic        checksum_valid
);

    localparam int LINE_LEN  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic             hs_reg, vs_reg;
    logic [11:0]      rgb_reg;
    logic [9:0]       x_reg, x_next;
    logic [9:0]       y_reg, y_next;
    logic             x_wrap;
    lock_state_t      state_reg, state_next;
    logic             lines_ok_reg, lines_ok_next;
    logic [15:0]      frame_count_reg;
    logic [7:0]       error_count_reg;
    logic             hfall, vfall, h_timeout, v_timeout;
    logic [CNT_W-1:0] h_period, h_width, v_period, v_width;
    logic             line_good, frame_good, bad_line, bad_frame, timeout, err_event;

    sync_edge_meter #(.LIMIT(2 * LINE_LEN)) u_hmeter (
        .clk        (clk),
        .rst        (rst),
        .sig_staged (hs_reg),
        .sig_in     (hsync),
        .en         (1'b1),
        .fall       (hfall),
        .period     (h_period),
        .width      (h_width),
        .timeout    (h_timeout)
    );

    sync_edge_meter #(.LIMIT(2 * FRAME_LEN)) u_vmeter (
        .clk        (clk),
        .rst        (rst),
        .sig_staged (vs_reg),
        .sig_in     (vsync),
        .en         (x_wrap),
        .fall       (vfall),
        .period     (v_period),
        .width      (v_width),
        .timeout    (v_timeout)
    );

    assign line_good  = (h_period == CNT_W'(LINE_LEN)) && (h_width == CNT_W'(H_SYNC));
    assign frame_good = (v_period == CNT_W'(FRAME_LEN)) && (v_width == CNT_W'(V_SYNC));
    assign bad_line   = hfall & ~line_good;
    assign bad_frame  = vfall & ~frame_good;
    assign timeout    = h_timeout | v_timeout;

    // Position of the staged sample; a sync fall re-anchors the counter.
    always_comb begin
        x_wrap = 1'b0;
        x_next = x_reg + 10'd1;
        y_next = y_reg;
        if (hfall) begin
            x_next = 10'(H_VISIBLE + H_FRONT);
        end else if (x_reg == 10'(LINE_LEN - 1)) begin
            x_next = '0;
            x_wrap = 1'b1;
        end
        if (vfall)
            y_next = 10'(V_VISIBLE + V_FRONT);
        else if (x_wrap)
            y_next = (y_reg == 10'(FRAME_LEN - 1)) ? '0 : y_reg + 10'd1;
    end

    always_comb begin
        state_next    = state_reg;
        lines_ok_next = lines_ok_reg;
        err_event     = 1'b0;
        if (vfall)
            lines_ok_next = 1'b1;
        else if (bad_line)
            lines_ok_next = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (vfall)
                    state_next = TRACK;
            end
            TRACK: begin
                if (timeout)
                    state_next = SEARCH;
                else if (vfall && lines_ok_reg && !bad_line && frame_good)
                    state_next = LOCKED;
            end
            LOCKED: begin
                if (bad_line || bad_frame || timeout) begin
                    state_next = SEARCH;
                    err_event  = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            rgb_reg         <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            state_reg       <= SEARCH;
            lines_ok_reg    <= 1'b0;
            frame_count_reg <= '0;
            error_count_reg <= '0;
        end else begin
            hs_reg       <= hsync;
            vs_reg       <= vsync;
            rgb_reg      <= {r_in, g_in, b_in};
            x_reg        <= x_next;
            y_reg        <= y_next;
            state_reg    <= state_next;
            lines_ok_reg <= lines_ok_next;
            if (vfall && state_reg == LOCKED)
                frame_count_reg <= frame_count_reg + 16'd1;
            if (err_event && error_count_reg != 8'hFF)
                error_count_reg <= error_count_reg + 8'd1;
        end
    end

    assign locked      = (state_reg == LOCKED);
    assign visible     = locked && (x_reg < 10'(H_VISIBLE)) && (y_reg < 10'(V_VISIBLE));
    assign position_x  = x_reg;
    assign position_y  = y_reg[8:0];
    assign r_out       = visible ? rgb_reg[11:8] : 4'd0;
    assign g_out       = visible ? rgb_reg[7:4]  : 4'd0;
    assign b_out       = visible ? rgb_reg[3:0]  : 4'd0;
    assign frame_count = frame_count_reg;
    assign error_count = error_count_reg;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] cs_reg;
    logic [15:0] frame_checksum_reg;
    logic        checksum_valid_reg;

    // The first visible pixel of a frame restarts the running sum from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_reg             <= '0;
            frame_checksum_reg <= '0;
            checksum_valid_reg <= 1'b0;
        end else begin
            checksum_valid_reg <= 1'b0;
            if (visible)
                cs_reg <= cs_step((x_reg == '0 && y_reg == '0) ? 16'h0000 : cs_reg, rgb_reg);
            if (locked && x_reg == '0 && y_reg == 10'(V_VISIBLE)) begin
                frame_checksum_reg <= cs_reg;
                checksum_valid_reg <= 1'b1;
            end
        end
    end

    assign frame_checksum = frame_checksum_reg;
    assign checksum_valid = checksum_valid_reg;
`else
    assign frame_checksum = '0;
    assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver using a shrunken timing so whole frames stay short.
module tb_vga_timing_receiver;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 4, VF = 2, VS = 2, VB = 2;
    localparam int WL = HV + HF + HS + HB;
    localparam int WF = VV + VF + VS + VB;
    localparam int STALL = 40;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1, vsync = 1'b1;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic [9:0]  position_x;
    logic [8:0]  position_y;
    logic        visible, locked, checksum_valid;
    logic [3:0]  r_out, g_out, b_out;
    logic [15:0] frame_count, frame_checksum;
    logic [7:0]  error_count;

    typedef struct {
        logic        vis;
        logic [31:0] word;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  vis_seen = 0;
    int  cs_pulses = 0;

    vga_timing_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hsync          (hsync),
        .vsync          (vsync),
        .r_in           (r_in),
        .g_in           (g_in),
        .b_in           (b_in),
        .position_x     (position_x),
        .position_y     (position_y),
        .visible        (visible),
        .r_out          (r_out),
        .g_out          (g_out),
        .b_out          (b_out),
        .locked         (locked),
        .frame_count    (frame_count),
        .error_count    (error_count),
        .frame_checksum (frame_checksum),
        .checksum_valid (checksum_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int x, input int y);
        logic [3:0] xv, yv;
        xv = 4'(x);
        yv = 4'(y);
        return {xv, yv, xv ^ yv ^ 4'hA};
    endfunction

    function automatic logic [15:0] model_cs();
        logic [15:0] cs;
        cs = 16'h0000;
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++)
                cs = {cs[14:0], cs[15]} ^ {4'b0000, pix(x, y)};
        return cs;
    endfunction

    // One clock: compare the output for the previously driven sample, then drive the next.
    task automatic step(input logic hs, input logic vs, input logic [11:0] rgb,
                        input logic exp_vis, input int x, input int y);
        sb_t e;
        @(negedge clk);
        if (visible) vis_seen++;
        if (checksum_valid) cs_pulses++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.vis)
                check_eq("pixel", {visible, position_x, position_y, r_out, g_out, b_out}, e.word);
            else
                check_eq("blank", {19'd0, visible, r_out, g_out, b_out}, e.word);
        end
        hsync = hs;
        vsync = vs;
        {r_in, g_in, b_in} = rgb;
        e.vis  = exp_vis;
        e.word = exp_vis ? {1'b1, 10'(x), 9'(y), rgb} : 32'd0;
        sb_q.push_back(e);
    endtask

    task automatic drive_frame(input string name, input bit lock_in, input int stretch_line,
                               input int stall_line, input int vs_w, input bit exp_locked,
                               input int exp_fc, input int exp_err);
        for (int vc = 0; vc < WF; vc++) begin
            bit lk, vs;
            lk = lock_in && !(stretch_line >= 0 && vc > stretch_line);
            vs = !(vc >= VV + VF && vc < VV + VF + vs_w);
            if (vc == stall_line)
                for (int i = 0; i < STALL; i++)
                    step(1'b1, vs, 12'hFFF, 1'b0, 0, 0);
            for (int hc = 0; hc < WL; hc++) begin
                bit hs, in_area;
                hs      = !(hc >= HV + HF && hc < HV + HF + HS);
                in_area = (hc < HV) && (vc < VV);
                step(hs, vs, pix(hc, vc), lk && in_area, hc, vc);
                if (vc == stretch_line && hc == HV + HF - 1)
                    step(hs, vs, pix(hc, vc), 1'b0, hc, vc);
            end
        end
        check_eq({name, " locked"}, 32'(locked), 32'(exp_locked));
        check_eq({name, " frame_count"}, 32'(frame_count), 32'(exp_fc));
        check_eq({name, " error_count"}, 32'(error_count), 32'(exp_err));
        $display("frame %s: locked=%0d frame_count=%0d error_count=%0d", name, locked, frame_count, error_count);
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        {r_in, g_in, b_in} = 12'hFFF;
        repeat (3) @(negedge clk);
        sb_q.delete();
        check_eq("rst position", 32'({position_x, position_y}), 32'd0);
        check_eq("rst flags", 32'({visible, locked, checksum_valid}), 32'd0);
        check_eq("rst colour", 32'({r_out, g_out, b_out}), 32'd0);
        check_eq("rst counts", {frame_count, 8'd0, error_count}, 32'd0);
        check_eq("rst checksum", 32'(frame_checksum), 32'd0);
        $display("reset: outputs checked with rst high");
        rst = 1'b0;
    endtask

    initial begin
        apply_reset();
        drive_frame("f0", 1'b0, -1, -1, VS, 1'b0, 0, 0);
        drive_frame("f1", 1'b0, -1, -1, VS, 1'b1, 0, 0);
        cs_pulses = 0;
        drive_frame("f2", 1'b1, -1, -1, VS, 1'b1, 1, 0);
        drive_frame("f3", 1'b1, -1, -1, VS, 1'b1, 2, 0);
        check_eq("checksum pulses", 32'(cs_pulses), CS_EN ? 32'd2 : 32'd0);
        check_eq("checksum value", 32'(frame_checksum), CS_EN ? 32'(model_cs()) : 32'd0);
        drive_frame("f4 stretched", 1'b1, 1, -1, VS, 1'b0, 2, 1);
        drive_frame("f5", 1'b0, -1, -1, VS, 1'b1, 2, 1);
        drive_frame("f6", 1'b1, -1, -1, VS, 1'b1, 3, 1);
        drive_frame("f7 stall", 1'b1, -1, VV, VS, 1'b0, 3, 2);
        drive_frame("f8", 1'b0, -1, -1, VS, 1'b1, 3, 2);
        vis_seen = 0;
        drive_frame("f9", 1'b1, -1, -1, VS, 1'b1, 4, 2);
        check_eq("visible cycles", 32'(vis_seen), 32'(HV * VV));
        apply_reset();
        drive_frame("f10 wide vsync", 1'b0, -1, -1, 3, 1'b0, 0, 0);
        drive_frame("f11", 1'b0, -1, -1, VS, 1'b0, 0, 0);
        drive_frame("f12", 1'b0, -1, -1, VS, 1'b1, 0, 0);
        drive_frame("f13", 1'b1, -1, -1, VS, 1'b1, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
